// File: rtl/pia_porta_source_if.sv
// Stream-side and PIA-side signals of the port A device transmitter.
// The master modport is the transmitter; the slave modport is the host stream plus the PIA.
interface pia_porta_source_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] PAO;
  logic       CA1;
  logic       CA2;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  tx_data, tx_valid, CA2,
    output tx_ready, PAO, CA1, busy, timeout_err
  );

  modport slave (
    output tx_data, tx_valid, CA2,
    input  tx_ready, PAO, CA1, busy, timeout_err
  );
endinterface

// File: rtl/pia_porta_source.sv
// MC6820 PIA port A device-end transmitter: present byte on PA, strobe CA1 low, wait for CA2 ack.
// Optional PIA_ACK_TIMEOUT_EN: abort WAIT_ACK after TIMEOUT_CYCLES with a timeout_err pulse.
module pia_porta_source #(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned STROBE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  pia_porta_source_if.master    bus
);

  localparam int unsigned MAX_AB = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned MAX_C  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
`ifdef PIA_ACK_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    STROBE   = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    pao_q;
  logic          ca1_q;
  logic          tx_ready_q;
  logic          busy_q;
  logic          tout_q;
  logic          ca2_s1_q;
  logic          ca2_s2_q;
  logic          ca2_prev_q;
  logic [CW-1:0] cnt_q;

  logic [CW-1:0] cnt_d;
  logic          ack_d;

  // Counter saturates so a long wait never wraps back into a terminal count.
  always_comb begin
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    ack_d = ca2_prev_q & ~ca2_s2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pao_q      <= '0;
      ca1_q      <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tout_q     <= 1'b0;
      ca2_s1_q   <= 1'b1;
      ca2_s2_q   <= 1'b1;
      ca2_prev_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      ca2_s1_q   <= bus.CA2;
      ca2_s2_q   <= ca2_s1_q;
      ca2_prev_q <= ca2_s2_q;
      tout_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.tx_valid) begin
            pao_q      <= bus.tx_data;
            cnt_q      <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            ca1_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            ca1_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= WAIT_ACK;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        WAIT_ACK: begin
          // Ack is checked first so a coincident timeout is suppressed.
          if (ack_d) begin
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
`ifdef PIA_ACK_TIMEOUT_EN
          end else if (cnt_q == TIMEOUT_LAST) begin
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            tout_q     <= 1'b1;
            cnt_q      <= '0;
            state_q    <= IDLE;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.PAO         = pao_q;
  assign bus.CA1         = ca1_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_pia_porta_source.sv
// Directed bench for pia_porta_source: default-timing instance and a SETUP=3/STROBE=2/TIMEOUT=8 instance.
module tb_pia_porta_source;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;

  pia_porta_source_if bus1();
  pia_porta_source_if bus2();

  pia_porta_source u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  pia_porta_source #(
    .SETUP_CYCLES   (3),
    .STROBE_CYCLES  (2),
    .TIMEOUT_CYCLES (8)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus1.tx_data = 8'h00; bus1.tx_valid = 1'b0; bus1.CA2 = 1'b1;
    bus2.tx_data = 8'h00; bus2.tx_valid = 1'b0; bus2.CA2 = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    check("rst_pao",   32'(bus1.PAO),         32'h00);
    check("rst_ca1",   32'(bus1.CA1),         32'h1);
    check("rst_ready", 32'(bus1.tx_ready),    32'h1);
    check("rst_busy",  32'(bus1.busy),        32'h0);
    check("rst_tout",  32'(bus1.timeout_err), 32'h0);

    // Send C1 with default timing, single-cycle CA2 ack
    bus1.tx_data = 8'hC1; bus1.tx_valid = 1'b1;
    tick(); // edge k
    bus1.tx_valid = 1'b0;
    check("c1_pao_k",   32'(bus1.PAO),      32'hC1);
    check("c1_busy_k",  32'(bus1.busy),     32'h1);
    check("c1_ready_k", 32'(bus1.tx_ready), 32'h0);
    check("c1_ca1_k",   32'(bus1.CA1),      32'h1);
    tick(); // k+1
    check("c1_ca1_k1",  32'(bus1.CA1),      32'h0);
    tick(); // k+2
    check("c1_ca1_k2",  32'(bus1.CA1),      32'h1);
    bus1.CA2 = 1'b0;
    tick(); // m
    bus1.CA2 = 1'b1;
    check("c1_ready_m",  32'(bus1.tx_ready), 32'h0);
    tick(); // m+1
    check("c1_ready_m1", 32'(bus1.tx_ready), 32'h0);
    check("c1_busy_m1",  32'(bus1.busy),     32'h1);
    tick(); // m+2
    check("c1_ready_m2", 32'(bus1.tx_ready), 32'h1);
    check("c1_busy_m2",  32'(bus1.busy),     32'h0);
    check("c1_pao_hold", 32'(bus1.PAO),      32'hC1);

    // CA2 low before WAIT_ACK and held low: no ack until high->low
    bus1.CA2 = 1'b0;
    repeat (4) tick();
    bus1.tx_data = 8'h55; bus1.tx_valid = 1'b1;
    tick();
    bus1.tx_valid = 1'b0;
    repeat (10) tick();
    check("low_busy",   32'(bus1.busy),     32'h1);
    check("low_ready",  32'(bus1.tx_ready), 32'h0);
    bus1.CA2 = 1'b1;
    repeat (4) tick();
    check("rise_busy",  32'(bus1.busy),     32'h1);
    bus1.CA2 = 1'b0;
    tick(); // m
    bus1.CA2 = 1'b1;
    tick(); // m+1
    check("fall_busy_m1",  32'(bus1.busy),     32'h1);
    tick(); // m+2
    check("fall_ready_m2", 32'(bus1.tx_ready), 32'h1);
    check("fall_pao",      32'(bus1.PAO),      32'h55);

    // Back-to-back with tx_valid held: 41 then 42
    bus1.tx_data = 8'h41; bus1.tx_valid = 1'b1;
    tick(); // k
    bus1.tx_data = 8'h42;
    check("b2b_pao_k",  32'(bus1.PAO), 32'h41);
    tick();
    tick(); // k+2, WAIT_ACK
    check("b2b_pao_k2", 32'(bus1.PAO), 32'h41);
    bus1.CA2 = 1'b0;
    tick(); // m
    bus1.CA2 = 1'b1;
    tick(); // m+1
    check("b2b_pao_m1",   32'(bus1.PAO),      32'h41);
    check("b2b_ready_m1", 32'(bus1.tx_ready), 32'h0);
    tick(); // m+2
    check("b2b_ready_m2", 32'(bus1.tx_ready), 32'h1);
    check("b2b_pao_m2",   32'(bus1.PAO),      32'h41);
    tick(); // m+3, second acceptance
    bus1.tx_valid = 1'b0;
    check("b2b_pao_m3",   32'(bus1.PAO),      32'h42);
    check("b2b_busy_m3",  32'(bus1.busy),     32'h1);
    tick();
    tick(); // WAIT_ACK
    bus1.CA2 = 1'b0;
    tick();
    bus1.CA2 = 1'b1;
    tick();
    tick();
    check("b2b_done", 32'(bus1.tx_ready), 32'h1);

    // Asynchronous reset during STROBE
    bus1.tx_data = 8'h77; bus1.tx_valid = 1'b1;
    tick(); // k
    bus1.tx_valid = 1'b0;
    tick(); // k+1, STROBE
    check("ar_ca1_pre", 32'(bus1.CA1), 32'h0);
    #1 reset = 1'b1;
    #1;
    check("ar_ca1",   32'(bus1.CA1),      32'h1);
    check("ar_ready", 32'(bus1.tx_ready), 32'h1);
    check("ar_busy",  32'(bus1.busy),     32'h0);
    check("ar_pao",   32'(bus1.PAO),      32'h00);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("ar_idle_ca1",  32'(bus1.CA1),  32'h1);
    check("ar_idle_busy", 32'(bus1.busy), 32'h0);

    // SETUP=3 / STROBE=2 waveform on the second instance
    begin
      logic [6:0] ca1_exp;
      ca1_exp = 7'b1100111; // bit i = CA1 after edge k+i
      bus2.tx_data = 8'hA5; bus2.tx_valid = 1'b1;
      tick(); // k
      bus2.tx_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
        check($sformatf("s3_ca1_k%0d", i), 32'(bus2.CA1), 32'(ca1_exp[i]));
        check($sformatf("s3_pao_k%0d", i), 32'(bus2.PAO), 32'hA5);
        if (i < 6) tick();
      end
    end
    // Now one edge past WAIT_ACK entry (entry at k+5, now after k+6).

`ifdef PIA_ACK_TIMEOUT_EN
    // No ack: timeout after 8 cycles in WAIT_ACK
    for (int i = 2; i <= 7; i++) begin
      tick(); // w+i
      check($sformatf("to_quiet_w%0d", i), 32'(bus2.timeout_err), 32'h0);
    end
    check("to_busy_w7",  32'(bus2.busy), 32'h1);
    tick(); // w+8
    check("to_pulse",    32'(bus2.timeout_err), 32'h1);
    check("to_ready",    32'(bus2.tx_ready),    32'h1);
    check("to_busy",     32'(bus2.busy),        32'h0);
    tick(); // w+9
    check("to_pulse_end", 32'(bus2.timeout_err), 32'h0);
`else
    bus2.CA2 = 1'b0;
    tick();
    bus2.CA2 = 1'b1;
    tick();
    tick();
    check("s3_ack_ready", 32'(bus2.tx_ready), 32'h1);

    // No ack and no timeout: busy stays high indefinitely
    bus1.tx_data = 8'h99; bus1.tx_valid = 1'b1;
    tick();
    bus1.tx_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      repeat (100) tick();
      check($sformatf("notimeout_busy_%0d", i * 100), 32'(bus1.busy), 32'h1);
      check($sformatf("notimeout_tout_%0d", i * 100), 32'(bus1.timeout_err), 32'h0);
    end
    bus1.CA2 = 1'b0;
    tick();
    bus1.CA2 = 1'b1;
    tick();
    tick();
    check("notimeout_ack", 32'(bus1.tx_ready), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
